fft_out_reorder: RTL

- Output reorder buffer placed after the last radix-2^2 SDF butterfly stage.
- The pipeline emits each N-point frame in bit-reversed order. This block writes frames into a ping-pong buffer at bit-reversed addresses and reads them out in natural order.
- It is the reader/de-scrambler counterpart to the butterfly chain that produces the scrambled stream.
- There is no backpressure: streaming in, streaming out.

---
 rtl/fft_out_reorder.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/fft_out_reorder.sv
// fft_out_reorder
//   Natural-order reorder buffer for the output of the radix-2^2 SDF FFT.
//   The butterfly chain emits every N-point frame in bit-reversed order.
//   Each sample is written into a ping-pong buffer at bitrev(position).
//   Full banks are then read out at natural addresses, one sample per
//   cycle. There is no backpressure in either direction.
//
// Ports
//   i_clk        rising-edge clock
//   i_rst        asynchronous, active-high reset
//   i_valid      input sample valid this cycle
//   i_sof        start of frame, qualified by i_valid
//   i_rX, i_iX   real / imaginary input, bit-reversed order
//   o_valid      output sample valid
//   o_sof        high with natural index 0
//   o_eof        high with natural index N-1
//   o_index      natural-order bin index of the output sample
//   o_rZ, o_iZ   real / imaginary output, natural order
//   o_busy       high while any bank is full or being read
//   o_dbgState   reader FSM state (1 = READ), for checkers
//
// Handshake: valid-only streaming. A sample transfers on every rising edge
// where its valid is high. There is no ready: the sink must accept every
// o_valid cycle. The source may insert i_valid gaps anywhere in a frame.
// Between output samples, o_index/o_rZ/o_iZ hold their last value.
module fft_out_reorder #(
    parameter int WIDTH  = 16,
    parameter int N_LOG2 = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    input  logic              i_sof,
    input  logic [WIDTH-1:0]  i_rX,
    input  logic [WIDTH-1:0]  i_iX,
    output logic              o_valid,
    output logic              o_sof,
    output logic              o_eof,
    output logic [N_LOG2-1:0] o_index,
    output logic [WIDTH-1:0]  o_rZ,
    output logic [WIDTH-1:0]  o_iZ,
    output logic              o_busy,
    output logic              o_dbgState
);

    localparam int N = 1 << N_LOG2;
    localparam logic [N_LOG2-1:0] LAST = N_LOG2'(N - 1);

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } readStateT;

    function automatic logic [N_LOG2-1:0] bitRev(input logic [N_LOG2-1:0] v);
        logic [N_LOG2-1:0] r;
        for (int b = 0; b < N_LOG2; b++) begin
            r[b] = v[N_LOG2-1-b];
        end
        return r;
    endfunction

    // Ping-pong storage. Each entry holds {real, imag}.
    logic [2*WIDTH-1:0] mem [0:1][0:N-1];

    // ---------------- write side ----------------
    logic [N_LOG2-1:0] wCnt;
    logic [N_LOG2-1:0] wIdx;
    logic              wBank;
    logic              wDone;
    logic [1:0]        full;
    logic [1:0]        fullNext;
    logic [1:0]        setFull;
    logic [1:0]        clrFull;

    // i_sof restarts the frame in place. The abandoned partial data is
    // simply overwritten, and wBank is left unchanged.
    assign wIdx  = i_sof ? '0 : wCnt;
    assign wDone = i_valid && (wIdx == LAST);

    always_comb begin
        setFull = '0;
        if (wDone) begin
            setFull[wBank] = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_valid) begin
            mem[wBank][bitRev(wIdx)] <= {i_rX, i_iX};
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wCnt  <= '0;
            wBank <= 1'b0;
        end else if (i_valid) begin
            wCnt <= wDone ? '0 : wIdx + N_LOG2'(1);
            if (wDone) begin
                wBank <= ~wBank;
            end
        end
    end

    // ---------------- read side ----------------
    readStateT         state;
    readStateT         nextState;
    logic [N_LOG2-1:0] rCnt;
    logic [N_LOG2-1:0] nextRCnt;
    logic              rBank;
    logic              nextRBank;
    logic              otherBank;
    logic              present;
    logic [2*WIDTH-1:0] rdWord;

    assign otherBank = ~rBank;
    assign rdWord    = mem[rBank][rCnt];

    // IDLE presents index 0 on the same edge it sees a full bank. This puts
    // index 0 one edge after the frame's last write.
    always_comb begin
        nextState = state;
        nextRCnt  = rCnt;
        nextRBank = rBank;
        clrFull   = '0;
        present   = 1'b0;
        case (state)
            IDLE: begin
                if (full[rBank]) begin
                    present   = 1'b1;
                    nextState = READ;
                end
            end
            READ: present = 1'b1;
            default: nextState = IDLE;
        endcase
        if (present) begin
            if (rCnt == LAST) begin
                clrFull[rBank] = 1'b1;
                nextRBank      = otherBank;
                nextRCnt       = '0;
                // A frame completing on this very edge still counts, so
                // back-to-back frames stream without a bubble.
                nextState = (full[otherBank] || setFull[otherBank]) ? READ : IDLE;
            end else begin
                nextRCnt = rCnt + N_LOG2'(1);
            end
        end
    end

    // Set and clear never target the same bank on one edge.
    assign fullNext = (full & ~clrFull) | setFull;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= IDLE;
            rCnt    <= '0;
            rBank   <= 1'b0;
            full    <= '0;
            o_valid <= 1'b0;
            o_sof   <= 1'b0;
            o_eof   <= 1'b0;
            o_index <= '0;
            o_rZ    <= '0;
            o_iZ    <= '0;
            o_busy  <= 1'b0;
        end else begin
            state   <= nextState;
            rCnt    <= nextRCnt;
            rBank   <= nextRBank;
            full    <= fullNext;
            // Registered image of |full | READ for the state being entered.
            o_busy  <= (|fullNext) || (nextState == READ);
            o_valid <= present;
            if (present) begin
                o_index <= rCnt;
                o_rZ    <= rdWord[2*WIDTH-1:WIDTH];
                o_iZ    <= rdWord[WIDTH-1:0];
                o_sof   <= (rCnt == '0);
                o_eof   <= (rCnt == LAST);
            end else begin
                o_sof <= 1'b0;
                o_eof <= 1'b0;
            end
        end
    end

    assign o_dbgState = (state == READ);

endmodule
